// File: rtl/bus_sram_responder_pkg.sv
// Shared definitions for the external-SRAM bus responder.
// Holds the FSM state encoding, the SRAM data width and the width of the
// strobe-pulse down-counter. The package has no ports.
package bus_sram_responder_pkg;

    localparam int SRAM_DATA_WIDTH     = 16;
    localparam int PULSE_COUNTER_WIDTH = 4;

    // Each 32-bit transaction runs as a LO half-word access and then a HI one.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LO_SETUP = 3'd1,
        LO_PULSE = 3'd2,
        LO_HOLD  = 3'd3,
        HI_SETUP = 3'd4,
        HI_PULSE = 3'd5,
        HI_HOLD  = 3'd6,
        DONE     = 3'd7
    } state_t;

endpackage

// File: rtl/bus_sram_responder.sv
// Bus responder that turns one 32-bit request/ready transaction into two
// 16-bit accesses on an external asynchronous SRAM (LO half first).
// Each half-word access is SETUP (1 cycle), PULSE (WAIT_CYCLES+1 cycles) and
// HOLD (1 cycle). All outputs come straight from flops.
// Ports:
//   i_clock, i_reset            clock, synchronous active-high reset
//   i_request/i_rw/i_address/i_wdata   initiator request, latched on acceptance
//   o_rdata, o_ready            read data and level completion flag
//   o_sram_address/o_sram_data/o_sram_data_oe   SRAM address, pad data, pad drive enable
//   i_sram_data                 data returned by the pads
//   o_sram_ce_n/o_sram_oe_n/o_sram_we_n         active-low SRAM strobes
module bus_sram_responder
    import bus_sram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_request,
    input  logic                          i_rw,
    input  logic [31:0]                   i_address,
    input  logic [31:0]                   i_wdata,
    output logic [31:0]                   o_rdata,
    output logic                          o_ready,
    output logic [ADDR_WIDTH-1:0]         o_sram_address,
    output logic [SRAM_DATA_WIDTH-1:0]    o_sram_data,
    output logic                          o_sram_data_oe,
    input  logic [SRAM_DATA_WIDTH-1:0]    i_sram_data,
    output logic                          o_sram_ce_n,
    output logic                          o_sram_oe_n,
    output logic                          o_sram_we_n
);

    localparam int WORD_WIDTH = ADDR_WIDTH - 1;
    localparam logic [PULSE_COUNTER_WIDTH-1:0] PULSE_LOAD = PULSE_COUNTER_WIDTH'(WAIT_CYCLES);
    localparam logic [PULSE_COUNTER_WIDTH-1:0] PULSE_ONE  = PULSE_COUNTER_WIDTH'(1);
    localparam logic [PULSE_COUNTER_WIDTH-1:0] PULSE_ZERO = PULSE_COUNTER_WIDTH'(0);

    state_t                         state_q, state_d;
    logic [PULSE_COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                           rw_q, rw_d;
    logic [WORD_WIDTH-1:0]          word_q, word_d;
    logic [31:0]                    wdata_q, wdata_d;
    logic [SRAM_DATA_WIDTH-1:0]     lo_q, lo_d;
    logic [SRAM_DATA_WIDTH-1:0]     hi_q, hi_d;
    logic                           ready_q, ready_d;
    logic [31:0]                    rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]          sram_addr_q, sram_addr_d;
    logic [SRAM_DATA_WIDTH-1:0]     sram_data_q, sram_data_d;
    logic                           data_oe_q, data_oe_d;
    logic                           ce_n_q, ce_n_d;
    logic                           oe_n_q, oe_n_d;
    logic                           we_n_q, we_n_d;

    // Byte-lane bits and bits above the SRAM are don't-care, so memory aliases.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_address[31:ADDR_WIDTH+1], i_address[1:0]};

    // Next-state and next-output logic of the access sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        ready_d     = ready_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        sram_data_d = sram_data_q;
        data_oe_d   = data_oe_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        case (state_q)
            IDLE: begin
                if (i_request) begin
                    // Outputs for LO_SETUP are loaded on the accepting edge.
                    rw_d        = i_rw;
                    word_d      = i_address[ADDR_WIDTH:2];
                    wdata_d     = i_wdata;
                    sram_addr_d = {i_address[ADDR_WIDTH:2], 1'b0};
                    sram_data_d = i_rw ? i_wdata[15:0] : 16'h0000;
                    data_oe_d   = i_rw;
                    ce_n_d      = 1'b0;
                    state_d     = LO_SETUP;
                end else begin
                    state_d     = IDLE;
                end
            end
            LO_SETUP, HI_SETUP: begin
                cnt_d = PULSE_LOAD;
                if (rw_q) begin
                    we_n_d = 1'b0;
                end else begin
                    oe_n_d = 1'b0;
                end
                state_d = (state_q == LO_SETUP) ? LO_PULSE : HI_PULSE;
            end
            LO_PULSE, HI_PULSE: begin
                if (cnt_q == PULSE_ZERO) begin
                    // Read data is sampled on the edge that ends the strobe.
                    we_n_d = 1'b1;
                    oe_n_d = 1'b1;
                    if (!rw_q && (state_q == LO_PULSE)) begin
                        lo_d = i_sram_data;
                    end else begin
                        lo_d = lo_q;
                    end
                    if (!rw_q && (state_q == HI_PULSE)) begin
                        hi_d = i_sram_data;
                    end else begin
                        hi_d = hi_q;
                    end
                    state_d = (state_q == LO_PULSE) ? LO_HOLD : HI_HOLD;
                end else begin
                    cnt_d = cnt_q - PULSE_ONE;
                end
            end
            LO_HOLD: begin
                // ce_n and data_oe stay asserted straight into the HI half.
                sram_addr_d = {word_q, 1'b1};
                sram_data_d = rw_q ? wdata_q[31:16] : sram_data_q;
                state_d     = HI_SETUP;
            end
            HI_HOLD: begin
                ce_n_d      = 1'b1;
                data_oe_d   = 1'b0;
                sram_addr_d = {ADDR_WIDTH{1'b0}};
                sram_data_d = 16'h0000;
                // A request already withdrawn gets no completion pulse.
                ready_d     = i_request;
                if (!rw_q) begin
                    rdata_d = {hi_q, lo_q};
                end else begin
                    rdata_d = rdata_q;
                end
                state_d = DONE;
            end
            DONE: begin
                if (!i_request || !ready_q) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                ready_d     = 1'b0;
                sram_addr_d = {ADDR_WIDTH{1'b0}};
                sram_data_d = 16'h0000;
                data_oe_d   = 1'b0;
                ce_n_d      = 1'b1;
                oe_n_d      = 1'b1;
                we_n_d      = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= IDLE;
            cnt_q       <= PULSE_ZERO;
            rw_q        <= 1'b0;
            word_q      <= {WORD_WIDTH{1'b0}};
            wdata_q     <= 32'h0000_0000;
            lo_q        <= 16'h0000;
            hi_q        <= 16'h0000;
            ready_q     <= 1'b0;
            rdata_q     <= 32'h0000_0000;
            sram_addr_q <= {ADDR_WIDTH{1'b0}};
            sram_data_q <= 16'h0000;
            data_oe_q   <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            sram_data_q <= sram_data_d;
            data_oe_q   <= data_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
        end
    end

    assign o_ready        = ready_q;
    assign o_rdata        = rdata_q;
    assign o_sram_address = sram_addr_q;
    assign o_sram_data    = sram_data_q;
    assign o_sram_data_oe = data_oe_q;
    assign o_sram_ce_n    = ce_n_q;
    assign o_sram_oe_n    = oe_n_q;
    assign o_sram_we_n    = we_n_q;

endmodule

// File: tb/tb_bus_sram_responder.sv
// Self-checking bench for bus_sram_responder. Two instances (WAIT_CYCLES=2
// and WAIT_CYCLES=0) each get their own SRAM model, reference memory,
// driver and negedge monitor. Expected SRAM writes and bus responses are
// queued at issue time and popped by the monitor when the DUT shows them.
module tb_bus_sram_responder;

    localparam int AW = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Half-word index the SRAM should see for a byte address.
    function automatic int hw_idx(input logic [31:0] a, input int half);
        int word;
        word = int'(a >> 2) % (1 << (AW - 1));
        return word * 2 + half;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int W = (g == 0) ? 2 : 0;

        logic          rst = 1'b1;
        logic          req = 1'b0;
        logic          rw = 1'b0;
        logic [31:0]   addr = 32'h0;
        logic [31:0]   wdata = 32'h0;
        logic [31:0]   rdata;
        logic          ready;
        logic [AW-1:0] sram_addr;
        logic [15:0]   sram_dout;
        logic [15:0]   sram_din = 16'h5A5A;
        logic          data_oe, ce_n, oe_n, we_n;
        bit            done = 1'b0;

        logic [15:0]    sram_mem [int];
        logic [15:0]    ref_mem [int];
        logic [AW+15:0] exp_wr_q [$];
        logic [32:0]    exp_rsp_q [$];

        bus_sram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) u_dut (
            .i_clock        (clk),
            .i_reset        (rst),
            .i_request      (req),
            .i_rw           (rw),
            .i_address      (addr),
            .i_wdata        (wdata),
            .o_rdata        (rdata),
            .o_ready        (ready),
            .o_sram_address (sram_addr),
            .o_sram_data    (sram_dout),
            .o_sram_data_oe (data_oe),
            .i_sram_data    (sram_din),
            .o_sram_ce_n    (ce_n),
            .o_sram_oe_n    (oe_n),
            .o_sram_we_n    (we_n)
        );

        function automatic string nm(input string s);
            return $sformatf("w%0d_%s", W, s);
        endfunction

        function automatic logic [15:0] ref_rd(input int i);
            return ref_mem.exists(i) ? ref_mem[i] : 16'h0000;
        endfunction

        function automatic logic [31:0] rand_addr(input int word);
            logic [31:0] a;
            a = ($urandom() & 32'hFFF8_0000) | (32'(word) << 2) | 32'($urandom_range(0, 3));
            return a;
        endfunction

        // SRAM model plus protocol monitor and scoreboard, sampled at negedge.
        initial begin : monitor
            logic          prev_we, prev_oe, prev_ce, prev_rdy;
            logic [AW-1:0] prev_a, hold_a;
            logic [15:0]   prev_d, hold_d;
            logic [AW+15:0] ew;
            logic [32:0]   er;
            int            we_cnt, oe_cnt, ce_cnt;
            prev_we = 1'b1; prev_oe = 1'b1; prev_ce = 1'b1; prev_rdy = 1'b0;
            prev_a = '0; prev_d = 16'h0; hold_a = '0; hold_d = 16'h0;
            we_cnt = 0; oe_cnt = 0; ce_cnt = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    prev_we = 1'b1; prev_oe = 1'b1; prev_ce = 1'b1; prev_rdy = 1'b0;
                    we_cnt = 0; oe_cnt = 0; ce_cnt = 0;
                    sram_din = 16'h5A5A;
                    exp_wr_q.delete();
                end else begin
                    if (!ce_n && !we_n) sram_mem[int'(sram_addr)] = sram_dout;
                    if (!ce_n && !oe_n)
                        sram_din = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 16'h0000;
                    else
                        sram_din = 16'h5A5A;

                    if (!we_n) begin
                        if (prev_we) begin
                            we_cnt = 1; hold_a = sram_addr; hold_d = sram_dout;
                            chk(nm("we_setup_ce"), 32'(prev_ce), 32'd0);
                            chk(nm("we_setup_addr"), 32'(prev_a), 32'(sram_addr));
                            chk(nm("we_setup_data"), 32'(prev_d), 32'(sram_dout));
                            chk(nm("we_drive"), {data_oe, ce_n}, 32'd2);
                        end else begin
                            we_cnt++;
                            chk(nm("we_addr_stable"), 32'(sram_addr), 32'(hold_a));
                            chk(nm("we_data_stable"), 32'(sram_dout), 32'(hold_d));
                        end
                    end else if (!prev_we) begin
                        chk(nm("we_width"), we_cnt, W + 1);
                        chk(nm("hold_addr"), 32'(sram_addr), 32'(hold_a));
                        chk(nm("hold_data"), 32'(sram_dout), 32'(hold_d));
                        chk(nm("hold_drive"), {data_oe, ce_n}, 32'd2);
                        if (exp_wr_q.size() == 0) begin
                            chk(nm("wr_unexpected"), 32'd1, 32'd0);
                        end else begin
                            ew = exp_wr_q.pop_front();
                            chk(nm("wr_addr"), 32'(hold_a), 32'(ew[AW+15:16]));
                            chk(nm("wr_data"), 32'(hold_d), 32'(ew[15:0]));
                        end
                    end

                    if (!oe_n) begin
                        oe_cnt = prev_oe ? 1 : oe_cnt + 1;
                        chk(nm("rd_no_drive"), {data_oe, ce_n, we_n}, 32'd1);
                    end else if (!prev_oe) begin
                        chk(nm("oe_width"), oe_cnt, W + 1);
                    end

                    if (!ce_n) begin
                        ce_cnt = prev_ce ? 1 : ce_cnt + 1;
                    end else if (!prev_ce) begin
                        chk(nm("ce_window"), ce_cnt, 2 * W + 6);
                    end

                    if (ready && !prev_rdy) begin
                        chk(nm("done_idle_pads"), {ce_n, data_oe}, 32'd2);
                        if (exp_rsp_q.size() == 0) begin
                            chk(nm("rsp_unexpected"), 32'd1, 32'd0);
                        end else begin
                            er = exp_rsp_q.pop_front();
                            if (er[32]) chk(nm("rdata"), rdata, er[31:0]);
                        end
                    end

                    prev_we = we_n; prev_oe = oe_n; prev_ce = ce_n; prev_rdy = ready;
                    prev_a = sram_addr; prev_d = sram_dout;
                end
            end
        end

        // One full handshake; inputs are scrambled once the request is taken.
        task automatic do_xact(input bit wr, input logic [31:0] a, input logic [31:0] d);
            int lo, hi, cyc;
            bit got;
            logic [AW-1:0] la, ha;
            lo = hw_idx(a, 0);
            hi = hw_idx(a, 1);
            la = lo[AW-1:0];
            ha = hi[AW-1:0];
            if (wr) begin
                exp_wr_q.push_back({la, d[15:0]});
                exp_wr_q.push_back({ha, d[31:16]});
                ref_mem[lo] = d[15:0];
                ref_mem[hi] = d[31:16];
                exp_rsp_q.push_back({1'b0, 32'h0});
            end else begin
                exp_rsp_q.push_back({1'b1, ref_rd(hi), ref_rd(lo)});
            end
            req = 1'b1; rw = wr; addr = a; wdata = d;
            got = 1'b0; cyc = 0;
            while (!got && cyc < 64) begin
                @(posedge clk); #1;
                cyc++;
                if (ready) begin
                    got = 1'b1;
                end else begin
                    rw = 1'($urandom_range(0, 1));
                    addr = $urandom();
                    wdata = $urandom();
                end
            end
            chk(nm("completed"), 32'(got), 32'd1);
            if (got) begin
                chk(nm("latency"), cyc, 2 * W + 7);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    chk(nm("ready_held"), 32'(ready), 32'd1);
                end
            end
            req = 1'b0;
            @(posedge clk); #1;
            chk(nm("ready_drop"), 32'(ready), 32'd0);
        endtask

        // Reset in the middle of a write strobe, then normal traffic again.
        task automatic reset_test();
            int cyc;
            req = 1'b1; rw = 1'b1; addr = 32'h0000_0040; wdata = 32'hCAFE_F00D;
            cyc = 0;
            while (we_n && cyc < 32) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk(nm("rst_reached_pulse"), 32'(we_n), 32'd0);
            rst = 1'b1; req = 1'b0;
            @(posedge clk); #1;
            chk(nm("rst_strobes"), {we_n, oe_n, ce_n}, 32'd7);
            chk(nm("rst_drive_ready"), {data_oe, ready}, 32'd0);
            rst = 1'b0;
            do_xact(1'b1, 32'h0000_0040, 32'h0BAD_CAFE);
            do_xact(1'b0, 32'h0000_0040, 32'h0);
        endtask

        initial begin : stim
            logic [31:0] b2b_d;
            repeat (3) @(posedge clk);
            #1;
            chk(nm("rst_ready"), 32'(ready), 32'd0);
            chk(nm("rst_rdata"), rdata, 32'd0);
            chk(nm("rst_addr_data"), {14'd0, sram_addr}, 32'd0);
            chk(nm("rst_sram_data"), 32'(sram_dout), 32'd0);
            chk(nm("rst_pads"), {data_oe, ce_n, oe_n, we_n}, 32'd7);
            rst = 1'b0;

            do_xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
            do_xact(1'b0, 32'h0000_0010, 32'h0);
            do_xact(1'b1, 32'h0008_0010, 32'h1234_5678);
            do_xact(1'b0, 32'h0000_0010, 32'h0);

            for (int i = 0; i < 8; i++) begin
                b2b_d = $urandom();
                do_xact(1'b1, rand_addr(32 + i), b2b_d);
            end
            for (int i = 0; i < 8; i++) begin
                do_xact(1'b0, rand_addr(32 + i), 32'h0);
            end
            for (int i = 0; i < 24; i++) begin
                do_xact(1'($urandom_range(0, 1)), rand_addr($urandom_range(0, 15)), $urandom());
            end

            reset_test();

            repeat (2) @(posedge clk);
            #1;
            chk(nm("rsp_drained"), exp_rsp_q.size(), 32'd0);
            chk(nm("wr_drained"), exp_wr_q.size(), 32'd0);
            done = 1'b1;
        end
    end

    initial begin : main
        int cyc;
        cyc = 0;
        while (!(g_inst[0].done && g_inst[1].done) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        chk("all_done", {30'd0, g_inst[0].done, g_inst[1].done}, 32'd3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_sram_responder.md
Name: bus_sram_responder

Overview:
- Bus responder (target) for the single-word request/ready bus driven by the DMA engine and the CPU: accepts one 32-bit read or write per handshake.
- Executes each transaction on an external asynchronous 16-bit SRAM as two half-word accesses with programmable wait states.
- Sits behind the address decoder as the external-memory target; the pads (tristate) live outside the block.

Parameters:
- ADDR_WIDTH, 18, SRAM half-word address width (2^18 x 16 bit = 512 KiB).
- WAIT_CYCLES, 2, extra strobe-low cycles beyond the minimum one per half-word access (0..15).

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_request  in  1  bus request; held by the initiator until o_ready is seen.
- i_rw  in  1  1 = write, 0 = read.
- i_address  in  32  byte address.
- i_wdata  in  32  write data.
- o_rdata  out  32  read data, valid while o_ready = 1 on a read.
- o_ready  out  1  transaction complete; level signal, held until i_request drops.
- o_sram_address  out  ADDR_WIDTH  half-word address.
- o_sram_data  out  16  data to pads.
- o_sram_data_oe  out  1  pad output enable (1 = drive).
- i_sram_data  in  16  data from pads.
- o_sram_ce_n, o_sram_oe_n, o_sram_we_n  out  1 each  active-low SRAM strobes.

Behaviour:
- Reset and idle values: o_ready=0, o_rdata=0, o_sram_address=0, o_sram_data=0, o_sram_data_oe=0, ce_n/oe_n/we_n=1, state=IDLE. All outputs are registered.
- States: IDLE, LO_SETUP, LO_PULSE, LO_HOLD, HI_SETUP, HI_PULSE, HI_HOLD, DONE.
- IDLE: on an edge with i_request=1, latch i_rw, i_address and i_wdata, then go to LO_SETUP.
- Half-word address: {addr[ADDR_WIDTH:2], half}, with half=0 for LO and 1 for HI.
  - Little-endian: LO carries data[15:0], HI carries data[31:16].
  - addr[1:0] and addr[31:ADDR_WIDTH+1] are ignored, so the memory aliases.
- SETUP (1 cycle): ce_n=0, address valid. On a write, data_oe=1 and o_sram_data is driven.
- PULSE (WAIT_CYCLES+1 cycles, counted by a 4-bit down-counter):
  - write: we_n=0.
  - read: oe_n=0; i_sram_data is captured on the edge that ends the final PULSE cycle.
- HOLD (1 cycle): strobes return high; ce_n stays 0; on a write, address and data are held and data_oe stays 1.
- Transitions:
  - LO_HOLD -> HI_SETUP.
  - HI_HOLD -> DONE with o_ready<=1. On a read, o_rdata<={hi,lo} in the same edge.
  - ce_n=1 and data_oe=0 in DONE.
- Latency: o_ready rises 2*WAIT_CYCLES+6 edges after the accepting edge (10 at the default).
- DONE: o_ready stays 1 while i_request=1. The first edge with i_request=0 sets o_ready<=0 and returns to IDLE.
  - A new request may be accepted on the following edge.
  - This supports the initiator pattern of dropping the request for exactly one cycle between transactions.
- Request dropped before DONE (protocol violation): the SRAM sequence still completes, so writes are never truncated. In DONE with i_request=0, go straight to IDLE without asserting o_ready.
- i_rw, i_address and i_wdata changing mid-transaction are ignored; only the latched copies are used.
- Reset at any point: the next edge forces reset values, so a write strobe is never extended past reset. A partial write is allowed.
- At most one outstanding transaction. No request is accepted outside IDLE.

Decomposition:
- Package bus_sram_responder_pkg holds:
  - state_t, a 3-bit enum of the states above.
  - Localparam SRAM_DATA_WIDTH=16.
  - Localparam PULSE_COUNTER_WIDTH=4.
- No sub-module: the FSM plus the down-counter are one block. Pads and the tristate are instantiated at the top level.

Test Plan:
- Write 0xDEADBEEF to 0x00000010, WAIT_CYCLES=2 -> SRAM model sees:
  - half-word 8 = 0xBEEF, then half-word 9 = 0xDEAD;
  - we_n low for 3 cycles each, with address and data stable from SETUP through HOLD;
  - o_ready high 10 edges after acceptance, held until i_request drops.
- Read 0x00000010 after the above -> oe_n low for 3 cycles per half; o_rdata=0xDEADBEEF when o_ready rises.
- Back-to-back DMA-style traffic: 8 writes with a one-cycle request gap, then 8 reads -> each accepted on the edge after the gap; all data matches; no overlapping ce_n windows.
- WAIT_CYCLES=0 -> latency 6 edges; we_n pulse exactly 1 cycle.
- Aliasing: write 0x12345678 to 0x00080010, read 0x00000010 -> 0x12345678 (ADDR_WIDTH=18).
- Reset asserted during LO_PULSE of a write -> next edge: we_n=1, ce_n=1, data_oe=0, o_ready=0, state IDLE; a subsequent request completes normally.
